shift_exec_stage: RTL and testbench

- Execute-stage shift unit for the 32-bit CPU. It sits between the D/X latch and the X/M latch.
- It decodes the shift op, computes SLL/SRL/SRA results with log-stage barrel networks, and registers the result.
- It uses a valid/ready handshake with a 2-entry skid buffer, so upstream stalls are fully registered.
- It supports a pipeline flush on branch mispredict.

---
 rtl/shift_exec_stage.sv | 187 ++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Execute-stage shifter: SLL/SRA/SRL/PASS through a 5-level barrel network, result registered with its tag.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: 2-entry skid (M + S); in_ready comes straight from a flop, with no path from out_ready.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_data, in_shamt, in_op, in_tag are the operation
//   flush                 drop every buffered operation (branch mispredict)
//   out_valid/out_ready   downstream handshake; out_data, out_tag, out_zero come from register M
// Optional: define SHIFT_EXEC_STAGE_STATS_EN to add the stat_ops / stat_stalls counters.

module shift_exec_stage #(
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [4:0]       in_shamt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero
`ifdef SHIFT_EXEC_STAGE_STATS_EN
   ,
   output logic [31:0]      stat_ops,
   output logic [31:0]      stat_stalls
`endif
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRA = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_TWO   = 2'b10;

   logic [1:0]       r_state;
   logic [31:0]      r_m_dat;
   logic [TAG_W-1:0] r_m_tag;
   logic             r_m_zero;
   logic [31:0]      r_s_dat;
   logic [TAG_W-1:0] r_s_tag;
   logic             r_in_ready;

   logic [31:0]      w_shift;
   logic             w_acc;
   logic             w_xfer;
   logic [1:0]       w_nxt_state;
   logic [31:0]      w_nxt_m_dat;
   logic [TAG_W-1:0] w_nxt_m_tag;
   logic [31:0]      w_nxt_s_dat;
   logic [TAG_W-1:0] w_nxt_s_tag;

   // Barrel network: stage k shifts by 2**k when shamt bit k is set.
   // PASS falls through every stage untouched, so shamt is ignored for it.
   always_comb begin
      w_shift = in_data;
      for (int k = 0; k < 5; k++) begin
         if (in_shamt[k]) begin
            case (in_op)
               OP_SLL:  w_shift = w_shift << (1 << k);
               OP_SRA:  w_shift = $unsigned($signed(w_shift) >>> (1 << k));
               OP_SRL:  w_shift = w_shift >> (1 << k);
               default: w_shift = w_shift;
            endcase
         end
      end
   end

   assign w_acc  = in_valid && r_in_ready;
   assign w_xfer = (r_state != ST_EMPTY) && out_ready;

   // Next-state logic. A slot that empties is cleared to zero, so out_data
   // reads 0 and out_zero reads 1 whenever out_valid is low.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_m_dat = r_m_dat;
      w_nxt_m_tag = r_m_tag;
      w_nxt_s_dat = r_s_dat;
      w_nxt_s_tag = r_s_tag;
      if (flush) begin
         // Flush beats any same-cycle accept or transfer.
         w_nxt_state = ST_EMPTY;
         w_nxt_m_dat = '0;
         w_nxt_m_tag = '0;
         w_nxt_s_dat = '0;
         w_nxt_s_tag = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_nxt_state = ST_ONE;
                  w_nxt_m_dat = w_shift;
                  w_nxt_m_tag = in_tag;
               end
            end
            ST_ONE: begin
               if (w_acc && w_xfer) begin
                  w_nxt_m_dat = w_shift;
                  w_nxt_m_tag = in_tag;
               end else if (w_xfer) begin
                  w_nxt_state = ST_EMPTY;
                  w_nxt_m_dat = '0;
                  w_nxt_m_tag = '0;
               end else if (w_acc) begin
                  w_nxt_state = ST_TWO;
                  w_nxt_s_dat = w_shift;
                  w_nxt_s_tag = in_tag;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so the only event is a transfer.
               if (w_xfer) begin
                  w_nxt_state = ST_ONE;
                  w_nxt_m_dat = r_s_dat;
                  w_nxt_m_tag = r_s_tag;
                  w_nxt_s_dat = '0;
                  w_nxt_s_tag = '0;
               end
            end
            default: begin
               w_nxt_state = ST_EMPTY;
               w_nxt_m_dat = '0;
               w_nxt_m_tag = '0;
               w_nxt_s_dat = '0;
               w_nxt_s_tag = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_m_dat    <= '0;
         r_m_tag    <= '0;
         r_m_zero   <= 1'b1;
         r_s_dat    <= '0;
         r_s_tag    <= '0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_nxt_state;
         r_m_dat    <= w_nxt_m_dat;
         r_m_tag    <= w_nxt_m_tag;
         r_m_zero   <= (w_nxt_m_dat == 32'd0);
         r_s_dat    <= w_nxt_s_dat;
         r_s_tag    <= w_nxt_s_tag;
         // Registered copy of "S empty", so in_ready never sees out_ready combinationally.
         r_in_ready <= (w_nxt_state != ST_TWO);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = r_m_dat;
   assign out_tag   = r_m_tag;
   assign out_zero  = r_m_zero;

`ifdef SHIFT_EXEC_STAGE_STATS_EN
   logic [31:0] r_stat_ops;
   logic [31:0] r_stat_stalls;

   // Counters ignore flush: a transfer in a flush cycle still completed downstream.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_ops    <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_xfer)
            r_stat_ops <= r_stat_ops + 32'd1;
         if (in_valid && !r_in_ready)
            r_stat_stalls <= r_stat_stalls + 32'd1;
      end
   end

   assign stat_ops    = r_stat_ops;
   assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        out_zero;
`ifdef SHIFT_EXEC_STAGE_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_stalls;
`endif

   always #5 clock = ~clock;

   shift_exec_stage #(.TAG_W(5)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_zero(out_zero)
`ifdef SHIFT_EXEC_STAGE_STATS_EN
      , .stat_ops(stat_ops), .stat_stalls(stat_stalls)
`endif
   );

   localparam logic [1:0] SLL  = 2'b00;
   localparam logic [1:0] SRA  = 2'b01;
   localparam logic [1:0] SRL  = 2'b10;
   localparam logic [1:0] PASS = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] dat;
      logic [4:0]  sh;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   typedef struct packed {
      logic [31:0] dat;
      logic [4:0]  tag;
   } res_t;

   vec_t        vecs [12];
   res_t        sb [$];
   res_t        e;
   logic [31:0] cur_exp;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: one bit position per step, independent of the barrel structure.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < int'(sh); i++) begin
         case (op)
            SLL:     r = {r[30:0], 1'b0};
            SRA:     r = {r[31], r[31:1]};
            SRL:     r = {1'b0, r[31:1]};
            default: r = r;
         endcase
      end
      return r;
   endfunction

   task automatic drive(input logic [1:0] op, input logic [31:0] dat, input logic [4:0] sh,
                        input logic [4:0] tag, input logic [31:0] exp);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = dat;
      in_shamt = sh;
      in_tag   = tag;
      cur_exp  = exp;
   endtask

   task automatic drive_pass(input logic [4:0] tag);
      logic [31:0] d;
      d = {27'd0, tag} * 32'h0111_0101 + 32'h0000_1000;
      drive(PASS, d, 5'($urandom_range(0, 31)), tag, model(PASS, d, 5'd0));
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({pfx, "_data"},  out_data, 32'd0);
      chk({pfx, "_tag"},   {27'd0, out_tag}, 32'd0);
      chk({pfx, "_zero"},  {31'd0, out_zero}, 32'd1);
      chk({pfx, "_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   // Scoreboard: push on accept, pop and compare on transfer.
   always @(posedge clock) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual tag=%0d data=%h required=no output", out_tag, out_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.dat);
               chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
               chk("out_zero", {31'd0, out_zero}, {31'd0, (e.dat == 32'd0)});
            end
         end
         if (flush)
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back({cur_exp, in_tag});
      end
   end

   initial begin
      vecs[0]  = '{SRA,  32'h8000_0000, 5'd31, 5'd0,  32'hFFFF_FFFF};
      vecs[1]  = '{SRL,  32'h8000_0000, 5'd4,  5'd1,  32'h0800_0000};
      vecs[2]  = '{SLL,  32'h0000_0001, 5'd31, 5'd2,  32'h8000_0000};
      vecs[3]  = '{PASS, 32'h1234_ABCD, 5'd7,  5'd3,  32'h1234_ABCD};
      vecs[4]  = '{SRL,  32'h0000_0001, 5'd1,  5'd4,  32'h0000_0000};
      vecs[5]  = '{SLL,  32'hDEAD_BEEF, 5'd0,  5'd5,  32'hDEAD_BEEF};
      vecs[6]  = '{SRA,  32'h7FFF_FFF0, 5'd4,  5'd6,  32'h07FF_FFFF};
      vecs[7]  = '{SRA,  32'hF000_0000, 5'd4,  5'd7,  32'hFF00_0000};
      vecs[8]  = '{SRL,  32'hF000_0000, 5'd4,  5'd8,  32'h0F00_0000};
      vecs[9]  = '{SLL,  32'h0000_FFFF, 5'd16, 5'd9,  32'hFFFF_0000};
      vecs[10] = '{SRA,  32'h8000_0000, 5'd0,  5'd10, 32'h8000_0000};
      vecs[11] = '{SRL,  32'hFFFF_FFFF, 5'd31, 5'd11, 32'h0000_0001};

      // Reset with in_valid high: the input must be ignored.
      reset = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      drive(SLL, 32'h5555_5555, 5'd3, 5'd31, 32'hAAAA_AAA8);
      repeat (2) @(negedge clock);
      chk_reset_vals("rst");
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

      // Table: one op per cycle, result one cycle after accept.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].op, vecs[i].dat, vecs[i].sh, vecs[i].tag, vecs[i].exp);
         @(negedge clock);
         chk("lat_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      @(negedge clock);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: tags 3,4 fill M and S, tag 5 waits upstream.
      out_ready = 1'b0;
      drive_pass(5'd3);
      @(negedge clock);
      chk("bp_rdy_one", {31'd0, in_ready}, 32'd1);
      drive_pass(5'd4);
      @(negedge clock);
      chk("bp_rdy_two", {31'd0, in_ready}, 32'd0);
      drive_pass(5'd5);
      @(negedge clock);
      chk("bp_rdy_hold", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_tag", {27'd0, out_tag}, 32'd3);
      @(negedge clock);
      chk("bp_hold_tag2", {27'd0, out_tag}, 32'd3);
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_nobubble4", {31'd0, out_valid}, 32'd1);
      chk("bp_tag4", {27'd0, out_tag}, 32'd4);
      @(negedge clock);
      in_valid = 1'b0;
      chk("bp_nobubble5", {31'd0, out_valid}, 32'd1);
      chk("bp_tag5", {27'd0, out_tag}, 32'd5);
      @(negedge clock);
      chk("bp_done", {31'd0, out_valid}, 32'd0);

      // Flush in TWO with an offered input and a same-cycle transfer.
      out_ready = 1'b0;
      drive_pass(5'd6);
      @(negedge clock);
      drive_pass(5'd7);
      @(negedge clock);
      chk("fl_two_rdy", {31'd0, in_ready}, 32'd0);
      drive_pass(5'd8);
      flush = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_ready", {31'd0, in_ready}, 32'd1);
      chk("fl_data", out_data, 32'd0);
      chk("fl_zero", {31'd0, out_zero}, 32'd1);
      repeat (2) @(negedge clock);
      chk("fl_no_tag8", {31'd0, out_valid}, 32'd0);

      // Flush in ONE beats a same-cycle accept.
      out_ready = 1'b0;
      drive_pass(5'd9);
      @(negedge clock);
      drive_pass(5'd10);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      chk("fl1_no_tag10", {31'd0, out_valid}, 32'd0);

      // Reset while in TWO.
      drive_pass(5'd11);
      @(negedge clock);
      drive_pass(5'd12);
      @(negedge clock);
      chk("rt_two_rdy", {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      drive_pass(5'd13);
      @(negedge clock);
      chk_reset_vals("rt");
      reset = 1'b0;
      out_ready = 1'b1;
      drive(SRA, 32'hC000_0000, 5'd1, 5'd14, model(SRA, 32'hC000_0000, 5'd1));
      @(negedge clock);
      in_valid = 1'b0;
      chk("rt_first_valid", {31'd0, out_valid}, 32'd1);
      chk("rt_first_tag", {27'd0, out_tag}, 32'd14);
      @(negedge clock);
      chk("rt_alone", {31'd0, out_valid}, 32'd0);

`ifdef SHIFT_EXEC_STAGE_STATS_EN
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("st_ops_rst", stat_ops, 32'd0);
      chk("st_stalls_rst", stat_stalls, 32'd0);
      out_ready = 1'b0;
      drive_pass(5'd20);
      @(negedge clock);
      drive_pass(5'd21);
      @(negedge clock);
      drive_pass(5'd22);
      repeat (3) @(negedge clock);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         drive_pass(5'(i));
         @(negedge clock);
      end
      in_valid = 1'b0;
      @(negedge clock);
      chk("st_ops10", stat_ops, 32'd10);
      chk("st_stalls3", stat_stalls, 32'd3);
      dut.r_stat_ops = 32'hFFFF_FFFF;
      drive_pass(5'd30);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      chk("st_wrap", stat_ops, 32'd0);
`endif

      @(negedge clock);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
